// File: rtl/soc_cpu_debug_pkg.sv
// Shared types and jdo field positions for the CPU debug memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package soc_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } ocimem_state_t;

  // Bit positions inside the 38-bit jdo word coming from the JTAG wrapper.
  localparam int JDO_RD_EN    = 35;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_ADDR_LO  = 17;

  // Pattern returned to the debugger when a read is abandoned.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/soc_cpu_ocimem_timeout.sv
// Stall watchdog: counts waitrequest cycles and flags when the budget is spent.
// Latency: expired is combinational from the registered count.
// Backpressure: none; the owner decides what to do when expired is high.
module soc_cpu_ocimem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = 16;

  logic [CNT_W-1:0] count;

  // Count stalled cycles; cleared whenever a new access starts.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // High during the stalled cycle that would use up the last allowed cycle,
  // so an access is never held by waitrequest for more than TIMEOUT cycles.
  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/soc_cpu_jtag_ocimem_sequencer.sv
// Executes JTAG debug memory reads/writes on an Avalon-MM master port.
// Latency: strobe to monitor_ready=1 is 2 cycles with zero wait states.
// Backpressure: request held while avm_waitrequest=1, aborted after TIMEOUT stalls.
module soc_cpu_jtag_ocimem_sequencer
  import soc_cpu_debug_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  ocimem_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [31:0]       wdata_nxt;
  logic [31:0]       mon_nxt;
  logic              rdy_nxt;
  logic              err_nxt;
  logic              tmo_clr;
  logic              tmo_expired;
  logic              any_strobe;

  // Only the read-enable, write-data and address fields of jdo matter here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Requests come straight from the registered state, so read and write can
  // never be high together and both drop on the edge that leaves the state.
  assign avm_read    = (state == ST_READ);
  assign avm_write   = (state == ST_WRITE);
  assign avm_address = addr;

  soc_cpu_ocimem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      ((state != ST_IDLE) && avm_waitrequest),
    .expired (tmo_expired)
  );

  // Command decode, access completion and timeout abort.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wdata_nxt = avm_writedata;
    mon_nxt   = MonDReg;
    rdy_nxt   = monitor_ready;
    err_nxt   = monitor_error;
    tmo_clr   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_nxt = jdo[JDO_ADDR_LO +: ADDR_W];
          // Clears the sticky error, unless a colliding strobe is dropped now.
          err_nxt  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[JDO_RD_EN]) begin
            state_nxt = ST_READ;
            rdy_nxt   = 1'b0;
            tmo_clr   = 1'b1;
          end else begin
            rdy_nxt   = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_nxt = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
          state_nxt = ST_WRITE;
          rdy_nxt   = 1'b0;
          tmo_clr   = 1'b1;
          if (take_no_action_ocimem_a) begin
            err_nxt = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          state_nxt = ST_READ;
          rdy_nxt   = 1'b0;
          tmo_clr   = 1'b1;
        end
      end

      ST_READ, ST_WRITE: begin
        // Commands cannot be queued while an access is outstanding.
        if (any_strobe) begin
          err_nxt = 1'b1;
        end
        if (!avm_waitrequest) begin
          if (state == ST_READ) begin
            mon_nxt = avm_readdata;
          end
          addr_nxt  = addr + 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_expired) begin
          if (state == ST_READ) begin
            mon_nxt = ERR_DATA;
          end
          rdy_nxt   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and monitor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      avm_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      avm_writedata <= wdata_nxt;
      MonDReg       <= mon_nxt;
      monitor_ready <= rdy_nxt;
      monitor_error <= err_nxt;
    end
  end

endmodule

// File: tb/tb_soc_cpu_jtag_ocimem_sequencer.sv
// Directed bench for the debug memory sequencer (TIMEOUT=4 instance).
// Latency: n/a.
// Backpressure: slave stalls are driven directly from the stimulus.
module tb_soc_cpu_jtag_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [9:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int total = 0;
  int bad   = 0;

  soc_cpu_jtag_ocimem_sequencer #(
    .ADDR_W   (10),
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic [9:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[26:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mon", MonDReg, 32'h0);
    chk("rst_rdy", {31'b0, monitor_ready}, 32'h0);
    chk("rst_err", {31'b0, monitor_error}, 32'h0);
    chk("rst_req", {30'b0, avm_read, avm_write}, 32'h0);
    chk("rst_addr", {22'b0, avm_address}, 32'h0);
    chk("rst_wdata", avm_writedata, 32'h0);

    // Address load with read at 0x010, zero wait states
    jdo = mk_a(1'b1, 10'h010);
    take_action_ocimem_a = 1'b1;
    avm_readdata = 32'h12345678;
    tick();
    chk("rd1_req", {30'b0, avm_read, avm_write}, 32'h2);
    chk("rd1_addr", {22'b0, avm_address}, 32'h010);
    chk("rd1_rdy_busy", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("rd1_mon", MonDReg, 32'h12345678);
    chk("rd1_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("rd1_req_off", {30'b0, avm_read, avm_write}, 32'h0);
    chk("rd1_addr_inc", {22'b0, avm_address}, 32'h011);

    // Write with 3 stall cycles: request visible for 4 cycles
    jdo = mk_b(32'hCAFEF00D);
    take_action_ocimem_b = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      avm_waitrequest = (i < 3);
      chk("wr_req", {30'b0, avm_read, avm_write}, 32'h1);
      chk("wr_data", avm_writedata, 32'hCAFEF00D);
      chk("wr_addr", {22'b0, avm_address}, 32'h011);
      tick();
    end
    chk("wr_req_off", {30'b0, avm_read, avm_write}, 32'h0);
    chk("wr_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("wr_mon_keep", MonDReg, 32'h12345678);
    chk("wr_addr_inc", {22'b0, avm_address}, 32'h012);
    chk("wr_err", {31'b0, monitor_error}, 32'h0);

    // Address-only load of 0x3FF, then read at current address wraps to 0
    jdo = mk_a(1'b0, 10'h3FF);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b0;
    tick();
    chk("ld_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("ld_req", {30'b0, avm_read, avm_write}, 32'h0);
    chk("ld_addr", {22'b0, avm_address}, 32'h3FF);
    take_no_action_ocimem_a = 1'b1;
    avm_readdata = 32'hA5A50001;
    tick();
    chk("nrd_req", {30'b0, avm_read, avm_write}, 32'h2);
    chk("nrd_addr", {22'b0, avm_address}, 32'h3FF);
    chk("nrd_rdy_busy", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("nrd_mon", MonDReg, 32'hA5A50001);
    chk("nrd_wrap", {22'b0, avm_address}, 32'h000);
    chk("nrd_rdy", {31'b0, monitor_ready}, 32'h1);

    // Read stalled forever: aborted after 4 stalled cycles
    jdo = mk_a(1'b1, 10'h155);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", {30'b0, avm_read, avm_write}, 32'h2);
      tick();
    end
    chk("tmo_req_off", {30'b0, avm_read, avm_write}, 32'h0);
    chk("tmo_mon", MonDReg, 32'hDEADBEEF);
    chk("tmo_err", {31'b0, monitor_error}, 32'h1);
    chk("tmo_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("tmo_addr", {22'b0, avm_address}, 32'h155);

    // Write strobe while a read is outstanding is dropped
    jdo = mk_a(1'b1, 10'h020);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    chk("busy_err_clr", {31'b0, monitor_error}, 32'h0);
    jdo = mk_b(32'h11112222);
    take_action_ocimem_b = 1'b1;
    tick();
    chk("busy_err", {31'b0, monitor_error}, 32'h1);
    chk("busy_req", {30'b0, avm_read, avm_write}, 32'h2);
    chk("busy_wdata", avm_writedata, 32'hCAFEF00D);
    chk("busy_addr", {22'b0, avm_address}, 32'h020);
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h600DF00D;
    tick();
    chk("busy_mon", MonDReg, 32'h600DF00D);
    chk("busy_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("busy_req_off", {30'b0, avm_read, avm_write}, 32'h0);
    chk("busy_addr_inc", {22'b0, avm_address}, 32'h021);
    chk("busy_err_sticky", {31'b0, monitor_error}, 32'h1);
    jdo = mk_a(1'b0, 10'h030);
    take_action_ocimem_a = 1'b1;
    tick();
    chk("clr_err", {31'b0, monitor_error}, 32'h0);
    chk("clr_addr", {22'b0, avm_address}, 32'h030);

    // Colliding a and b strobes: a wins, b dropped with error
    jdo = mk_a(1'b0, 10'h040) | mk_b(32'h0000_0000);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    chk("coll_err", {31'b0, monitor_error}, 32'h1);
    chk("coll_rdy", {31'b0, monitor_ready}, 32'h1);
    chk("coll_addr", {22'b0, avm_address}, 32'h040);
    chk("coll_req", {30'b0, avm_read, avm_write}, 32'h0);
    chk("coll_wdata", avm_writedata, 32'hCAFEF00D);

    // Reset during a stalled read
    jdo = mk_a(1'b1, 10'h050);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    chk("mrst_pre_req", {30'b0, avm_read, avm_write}, 32'h2);
    reset = 1'b1;
    tick();
    chk("mrst_req", {30'b0, avm_read, avm_write}, 32'h0);
    chk("mrst_mon", MonDReg, 32'h0);
    chk("mrst_rdy", {31'b0, monitor_ready}, 32'h0);
    chk("mrst_err", {31'b0, monitor_error}, 32'h0);
    chk("mrst_addr", {22'b0, avm_address}, 32'h0);
    chk("mrst_wdata", avm_writedata, 32'h0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    chk("mrst_idle_req", {30'b0, avm_read, avm_write}, 32'h0);
    chk("mrst_no_done", {31'b0, monitor_ready}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
